// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial arithmetic blocks.
package alu_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seqState_t;

    // Counter width for n slices; never narrower than one bit so n=1 still has a counter.
    function automatic int clog2(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/subtraction.sv
// 4-bit ripple-borrow subtractor: Y = A - B - BorrowIn, with signed overflow of this slice.
module subtraction
    import alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    input  logic                BorrowIn,
    output logic [NIBBLE_W-1:0] Y,
    output logic                BorrowOut,
    output logic                overflow
);

    always_comb begin
        logic [NIBBLE_W:0] brw;
        brw    = '0;
        brw[0] = BorrowIn;
        Y      = '0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            Y[i]     = A[i] ^ B[i] ^ brw[i];
            brw[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & brw[i]);
        end
        BorrowOut = brw[NIBBLE_W];
        // Only meaningful on the most-significant slice of a wider word.
        overflow  = (A[NIBBLE_W-1] ^ B[NIBBLE_W-1]) & (Y[NIBBLE_W-1] ^ A[NIBBLE_W-1]);
    end

endmodule

// File: rtl/serial_subtract_sequencer.sv
// Multi-precision A - B - borrow_in, one nibble per clock through a single 4-bit
// subtraction stage, LS nibble first, with a start/busy/done handshake.
module serial_subtract_sequencer
    import alu_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        borrow_in,
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLE_W*NIBBLES-1:0] diff,
    output logic                        borrow_out,
    output logic                        overflow,
    output logic                        zero
);

    localparam int WIDTH = NIBBLE_W * NIBBLES;
    localparam int CNT_W = clog2(NIBBLES);

    seqState_t state, nextState;
    logic launch;
    logic lastNibble;

    logic [WIDTH-1:0] aShift, bShift;
    logic             borrowReg;
    logic [CNT_W-1:0] nibbleCnt;

    logic [NIBBLE_W-1:0]       nibY;
    logic                      nibBorrow;
    logic                      nibOverflow;
    logic [WIDTH+NIBBLE_W-1:0] diffCat;
    logic [WIDTH-1:0]          nextDiff;

    subtraction uSub (
        .A        (aShift[NIBBLE_W-1:0]),
        .B        (bShift[NIBBLE_W-1:0]),
        .BorrowIn (borrowReg),
        .Y        (nibY),
        .BorrowOut(nibBorrow),
        .overflow (nibOverflow)
    );

    assign lastNibble = (nibbleCnt == CNT_W'(NIBBLES - 1));

    // New nibble enters at the top; after NIBBLES shifts the word is in place.
    assign diffCat  = {nibY, diff};
    assign nextDiff = diffCat[WIDTH+NIBBLE_W-1:NIBBLE_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        launch    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = RUN;
                    launch    = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (lastNibble) nextState = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    nextState = RUN;
                    launch    = 1'b1;
                end else begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aShift     <= '0;
            bShift     <= '0;
            borrowReg  <= 1'b0;
            nibbleCnt  <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
        end else if (launch) begin
            aShift     <= a;
            bShift     <= b;
            borrowReg  <= borrow_in;
            nibbleCnt  <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
        end else if (state == RUN) begin
            diff      <= nextDiff;
            aShift    <= aShift >> NIBBLE_W;
            bShift    <= bShift >> NIBBLE_W;
            borrowReg <= nibBorrow;
            nibbleCnt <= nibbleCnt + CNT_W'(1);
            if (lastNibble) begin
                borrow_out <= nibBorrow;
                overflow   <= nibOverflow;
                zero       <= (nextDiff == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtract_sequencer.sv
// Directed bench for serial_subtract_sequencer at NIBBLES=4 and NIBBLES=1.
module tb_serial_subtract_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        borrowIn = 1'b0;
    logic [15:0] a4 = '0, b4 = '0;
    logic [3:0]  a1 = '0, b1 = '0;

    logic        busy4, done4, bo4, ov4, zero4;
    logic [15:0] diff4;
    logic        busy1, done1, bo1, ov1, zero1;
    logic [3:0]  diff1;

    int checks = 0;
    int errors = 0;
    int lat, bc, lat2, bc2;
    logic sawDone;

    always #5 clk = ~clk;

    serial_subtract_sequencer #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .a(a4), .b(b4), .borrow_in(borrowIn),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4),
        .overflow(ov4), .zero(zero4)
    );

    serial_subtract_sequencer #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a1), .b(b1), .borrow_in(borrowIn),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1),
        .overflow(ov1), .zero(zero1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands and start for one edge; returns #1 after the accepting edge.
    task automatic startOp(input logic [15:0] av, input logic [15:0] bv, input logic bi);
        @(negedge clk);
        a4 = av; b4 = bv; borrowIn = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Edges until done4 is seen (0 = never within budget), and busy samples before it.
    task automatic waitDone(output int l, output int bcount);
        l = 0;
        bcount = busy4 ? 1 : 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (done4) begin
                l = i;
                break;
            end
            if (busy4) bcount++;
        end
    endtask

    task automatic runOp(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic bi, input logic [15:0] expDiff, input logic [2:0] expFlags);
        int l, bcount;
        startOp(av, bv, bi);
        waitDone(l, bcount);
        check({tag, "_lat"}, l, 4);
        check({tag, "_busycyc"}, bcount, 4);
        check({tag, "_diff"}, diff4, expDiff);
        check({tag, "_bo_ov_z"}, {bo4, ov4, zero4}, expFlags);
    endtask

    initial begin
        // Asynchronous reset, checked between clock edges.
        #2 rst = 1'b1;
        #1;
        check("rst_diff", diff4, 16'h0);
        check("rst_ctl", {busy4, done4, bo4, ov4, zero4}, 5'b0);
        @(negedge clk); rst = 1'b0;

        runOp("basic",   16'h1234, 16'h0123, 1'b0, 16'h1111, 3'b000);
        runOp("under",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 3'b100);
        runOp("ovf",     16'h8000, 16'h0001, 1'b0, 16'h7FFF, 3'b010);
        runOp("zero",    16'h5555, 16'h5555, 1'b0, 16'h0000, 3'b001);
        runOp("zero_bi", 16'h5555, 16'h5555, 1'b1, 16'hFFFF, 3'b100);

        // start pulsed mid-RUN with other operands must be ignored.
        startOp(16'h1234, 16'h0123, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        a4 = 16'hFFFF; b4 = 16'h0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitDone(lat, bc);
        check("midrun_lat", lat, 2);
        check("midrun_diff", diff4, 16'h1111);
        @(posedge clk); #1;
        check("midrun_idle", {busy4, done4}, 2'b00);

        // start held high through DONE: relaunch with no IDLE cycle.
        @(negedge clk);
        a4 = 16'h1234; b4 = 16'h0123; borrowIn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        waitDone(lat, bc);
        check("b2b_lat1", lat, 4);
        check("b2b_diff1", diff4, 16'h1111);
        a4 = 16'h8000; b4 = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_nogap", busy4, 1'b1);
        waitDone(lat2, bc2);
        check("b2b_gap", lat2 + 1, 5);
        check("b2b_diff2", diff4, 16'h7FFF);
        check("b2b_flags2", {bo4, ov4, zero4}, 3'b010);

        // Reset two cycles into RUN: immediate clear, no done pulse.
        startOp(16'h5555, 16'h1111, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_diff", diff4, 16'h0);
        check("midrst_ctl", {busy4, done4, bo4, ov4, zero4}, 5'b0);
        @(negedge clk); rst = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            sawDone = sawDone | done4;
        end
        check("midrst_nodone", sawDone, 1'b0);
        check("midrst_idle", busy4, 1'b0);
        runOp("postrst", 16'h5555, 16'h1111, 1'b0, 16'h4444, 3'b000);

        // NIBBLES=1 instance: single-cycle RUN.
        a1 = 4'h3; b1 = 4'h5;
        startOp(16'h0000, 16'h0000, 1'b0);
        check("n1_busy", busy1, 1'b1);
        @(posedge clk); #1;
        check("n1_done", done1, 1'b1);
        check("n1_diff", diff1, 4'hE);
        check("n1_flags", {bo1, ov1, zero1}, 3'b100);
        a1 = 4'h8; b1 = 4'h1;
        startOp(16'h0000, 16'h0000, 1'b0);
        @(posedge clk); #1;
        check("n1_ovf_done", done1, 1'b1);
        check("n1_ovf_diff", diff1, 4'h7);
        check("n1_ovf_flags", {bo1, ov1, zero1}, 3'b010);

        repeat (8) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtract_sequencer.md
# serial_subtract_sequencer

Multi-precision subtractor that computes A − B − borrow_in on a WIDTH-bit word by driving the team's 4-bit `subtraction` stage one nibble per clock, least-significant nibble first. It sits directly upstream of `subtraction`: it feeds operand nibbles and the chained borrow, and it consumes `Y`, `BorrowOut` and `overflow` back into result registers. A start/busy/done handshake connects it to the controlling datapath.

## Interface
- NIBBLES, default 4: number of 4-bit slices. WIDTH = 4*NIBBLES. Legal range is 1..16.

- clk  in  1  sole clock; all state changes on the rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request; sampled only when state is IDLE or DONE
- a  in  WIDTH  minuend, two's complement or unsigned
- b  in  WIDTH  subtrahend
- borrow_in  in  1  initial borrow into nibble 0
- busy  out  1  high while state is RUN
- done  out  1  one-cycle pulse; results are valid
- diff  out  WIDTH  A − B − borrow_in, modulo 2^WIDTH
- borrow_out  out  1  borrow out of the most-significant nibble
- overflow  out  1  signed overflow of the full-word subtraction
- zero  out  1  diff == 0

## Operation
- States:
  - IDLE: after reset.
  - RUN: nibbles are in process.
  - DONE: lasts one cycle.
- IDLE→RUN on start=1:
  - Latch a and b into shift registers.
  - Load the borrow register with borrow_in.
  - Clear the nibble counter.
  - Clear diff and all flags.
- RUN: each cycle `subtraction` receives the low nibble of each shift register and the borrow register. Then:
  - Y shifts into diff from the MSB end.
  - The a and b shift registers shift right by 4 bits.
  - The borrow register takes BorrowOut.
  - The counter increments.
- On the cycle where counter = NIBBLES−1:
  - borrow_out takes BorrowOut.
  - overflow takes the `subtraction` overflow output, which is evaluated on the MS nibble only and is therefore the correct full-word result.
  - zero is computed from the final diff.
  - The state moves to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Next state is RUN if start=1 (back-to-back operation, operands latched this edge), otherwise IDLE.
- start is ignored while in RUN. Operand inputs are not sampled after the launch edge.
- diff, borrow_out, overflow and zero hold their values until the next accepted start or reset.
- Arithmetic: the result is modulo 2^WIDTH and no sign extension is performed.
  - borrow_out=1 exactly when unsigned a < b + borrow_in.
  - overflow=1 exactly when sign(a) ≠ sign(b) and sign(diff) ≠ sign(a).

## Timing
- Reset (asynchronous, immediate):
  - State is IDLE.
  - busy, done, diff, borrow_out, overflow and zero are all 0.
  - Shift registers, counter and borrow register are 0.
- Reset mid-operation aborts with no done pulse. The first start after rst falls is accepted normally.
- Latency:
  - start is accepted at edge k.
  - busy is high from k to k+NIBBLES.
  - done and the final results are visible in the cycle following edge k+NIBBLES.
- Throughput is one operation per NIBBLES+1 cycles. Holding start high gives back-to-back operation.
- NIBBLES=1: RUN lasts one cycle and the counter has 1 bit minimum.
- A start asserted at the same edge that enters DONE is ignored, because it is sampled in RUN.

## Structure
- Shared package `alu_pkg` holds:
  - The state enum (IDLE, RUN, DONE).
  - NIBBLE_W = 4.
  - The counter width function clog2(NIBBLES).
- One sub-module instance: the existing `subtraction` (4-bit ripple with overflow). Do not duplicate its logic.
- Everything else is flat in one module: FSM, counter, shift registers, flag registers.

## Test plan
- NIBBLES=4, a=0x1234, b=0x0123, borrow_in=0 → diff=0x1111, borrow_out=0, overflow=0, zero=0. done fires 4 cycles after the start edge and busy is high for exactly 4 cycles.
- a=0x0000, b=0x0001 → diff=0xFFFF, borrow_out=1, overflow=0. Then a=0x8000, b=0x0001 → diff=0x7FFF, borrow_out=0, overflow=1.
- a=0x5555, b=0x5555, borrow_in=0 → diff=0x0000, zero=1. Same operands with borrow_in=1 → diff=0xFFFF, borrow_out=1, zero=0.
- Pulse start again mid-RUN with different operands → ignored, and the first result is unchanged. Holding start high through DONE → second operation starts without an IDLE cycle and its done follows 5 cycles after the first done.
- Assert rst two cycles into RUN → all outputs are 0 immediately, with no done pulse. A new start after release gives the correct result.
- NIBBLES=1, a=0x3, b=0x5 → diff=0xE, borrow_out=1, overflow=0, done one cycle after the start edge.
